// File: rtl/bsg_source_sync_word_narrow.sv
// Narrows a wide core word into channel_width_p-bit beats on valid/ready,
// with back-to-back words streamed without an idle bubble.
module bsg_source_sync_word_narrow #(
  parameter int width_p         = 32,
  parameter int channel_width_p = 8,
  parameter int msb_first_p     = 0,
  localparam int els_lp         = width_p / channel_width_p,
  localparam int lg_els_lp      = (els_lp > 1) ? $clog2(els_lp) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [channel_width_p-1:0] data_o,
  input  logic                       ready_i,
  output logic                       last_o,
  output logic [lg_els_lp-1:0]       beat_o
);

  if (((width_p % channel_width_p) != 0) || (els_lp < 2)) begin : g_bad_params
    $error("width_p must be a multiple of channel_width_p with at least 2 beats");
  end

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [width_p-1:0]   word_q, word_d;
  logic [lg_els_lp-1:0] cnt_q, cnt_d;

  logic [els_lp-1:0][channel_width_p-1:0] slice_w;
  logic                                   last_w;

  // Beat order is fixed at elaboration, so the slice mux is just a rewiring.
  for (genvar i = 0; i < els_lp; i++) begin : g_slice
    localparam int src_lp = (msb_first_p != 0) ? (els_lp - 1 - i) : i;
    assign slice_w[i] = word_q[src_lp*channel_width_p +: channel_width_p];
  end

  assign last_w  = (state_q == SEND) && (cnt_q == lg_els_lp'(els_lp - 1));
  assign v_o     = (state_q == SEND);
  assign beat_o  = cnt_q;
  assign last_o  = last_w;
  assign data_o  = slice_w[cnt_q];
  // The next word is taken in the same cycle the last beat leaves.
  assign ready_o = reset_n_i & ((state_q == IDLE) | (last_w & ready_i));

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (v_i) begin
          word_d  = data_i;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ready_i) begin
          if (last_w) begin
            cnt_d = '0;
            if (v_i) word_d  = data_i;
            else     state_d = IDLE;
          end else begin
            cnt_d = cnt_q + lg_els_lp'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bsg_source_sync_word_narrow.sv
// Three instances (32/8 lsb-first, 32/8 msb-first, 24/8) share stimulus; each is
// checked against its own beat queue filled on word acceptance.
module tb_bsg_source_sync_word_narrow;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_i;
  logic [31:0] data_i;
  logic        ready_i;

  logic       rdy0, rdy1, rdy2;
  logic       vo0, vo1, vo2;
  logic [7:0] d0, d1, d2;
  logic       last0, last1, last2;
  logic [1:0] beat0, beat1, beat2;

  always #5 clk = ~clk;

  bsg_source_sync_word_narrow #(.width_p(32), .channel_width_p(8), .msb_first_p(0)) u_lsb (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .data_i(data_i), .ready_o(rdy0),
    .v_o(vo0), .data_o(d0), .ready_i(ready_i), .last_o(last0), .beat_o(beat0));

  bsg_source_sync_word_narrow #(.width_p(32), .channel_width_p(8), .msb_first_p(1)) u_msb (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .data_i(data_i), .ready_o(rdy1),
    .v_o(vo1), .data_o(d1), .ready_i(ready_i), .last_o(last1), .beat_o(beat1));

  bsg_source_sync_word_narrow #(.width_p(24), .channel_width_p(8), .msb_first_p(0)) u_w24 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .data_i(data_i[23:0]), .ready_o(rdy2),
    .v_o(vo2), .data_o(d2), .ready_i(ready_i), .last_o(last2), .beat_o(beat2));

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic [1:0] b;
  } beat_t;

  beat_t q[3][$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    acc0    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Handshakes complete at the next posedge, so negedge samples see exactly what fires.
  task automatic mon(input int id, input logic rdy, input logic vo, input logic [7:0] d,
                     input logic last, input logic [1:0] b, input int els, input bit msb,
                     input logic [31:0] word);
    bit    has, exp_rdy;
    beat_t f, nb;
    int    idx;
    if (!rst_n) begin
      chk($sformatf("rdy_in_rst%0d", id), rdy, 0);
      q[id].delete();
      return;
    end
    has = (q[id].size() != 0);
    chk($sformatf("v_o%0d", id), vo, has);
    exp_rdy = !has || (q[id][0].last && ready_i);
    chk($sformatf("ready_o%0d", id), rdy, exp_rdy);
    if (has) begin
      f = q[id][0];
      chk($sformatf("data%0d", id), d, f.d);
      chk($sformatf("last%0d", id), last, f.last);
      chk($sformatf("beat%0d", id), b, f.b);
      if (ready_i) void'(q[id].pop_front());
    end
    if (v_i && exp_rdy) begin
      if (id == 0) acc0++;
      for (int k = 0; k < els; k++) begin
        idx    = msb ? (els - 1 - k) : k;
        nb.d   = 8'((word >> (8 * idx)) & 32'hFF);
        nb.last = (k == els - 1);
        nb.b   = 2'(k);
        q[id].push_back(nb);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rdy0, vo0, d0, last0, beat0, 4, 1'b0, data_i);
    mon(1, rdy1, vo1, d1, last1, beat1, 4, 1'b1, data_i);
    mon(2, rdy2, vo2, d2, last2, beat2, 3, 1'b0, {8'h00, data_i[23:0]});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  e_lsb[4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
  logic [7:0]  e_msb[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [7:0]  e_rst[4] = '{8'h88, 8'h77, 8'h66, 8'h55};
  logic [31:0] words[3] = '{32'h0102_0304, 32'hDEAD_BEEF, 32'hCAFE_F00D};

  initial begin
    int  w, cyc;
    bit  acc;
    rst_n = 1'b0; v_i = 1'b0; data_i = '0; ready_i = 1'b0;
    repeat (3) step();
    v_i = 1'b1;
    @(negedge clk);
    chk("rst_ready_low", rdy0, 0);
    step();
    v_i = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_v_o", vo0, 0);
    chk("rst_data_o", d0, 0);
    chk("rst_last_o", last0, 0);
    chk("rst_beat_o", beat0, 0);
    chk("idle_ready", rdy0, 1);

    // Single word, all three instances accept on the same edge.
    step();
    v_i = 1'b1; data_i = 32'hA1B2_C3D4; ready_i = 1'b1;
    step();
    v_i = 1'b0; data_i = 32'h5555_5555;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_v", vo0, 1);
      chk("t1_data", d0, e_lsb[k]);
      chk("t1_last", last0, k == 3);
      chk("t2_data", d1, e_msb[k]);
      chk("t2_beat", beat1, k);
      chk("t6_v", vo2, k < 3);
      if (k < 3) begin
        chk("t6_data", d2, e_lsb[k]);
        chk("t6_beat", beat2, k);
      end
    end
    @(negedge clk);
    chk("t1_idle_after", vo0, 0);

    // Three back-to-back words, no gap on v_o.
    step();
    w = 0; v_i = 1'b1; data_i = words[0];
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      chk("t3_v", vo0, i != 0);
      chk("t3_ready", rdy0, (i % 4) == 0);
      if (i != 0) chk("t3_beat", beat0, (i - 1) % 4);
      acc = v_i && rdy0;
      step();
      if (acc) begin
        w++;
        if (w == 3) v_i = 1'b0;
        else        data_i = words[w];
      end
    end
    v_i = 1'b0;
    repeat (6) step();

    // Reset while the second beat of a word is on the channel.
    v_i = 1'b1; data_i = 32'h1122_3344;
    step();
    v_i = 1'b0;
    step();
    chk("t5_beat1_data", d0, 8'h33);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_ready_rst", rdy0, 0);
    step();
    chk("t5_v_after", vo0, 0);
    chk("t5_beat_after", beat0, 0);
    rst_n = 1'b1;
    v_i = 1'b1; data_i = 32'h5566_7788;
    step();
    v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_data", d0, e_rst[k]);
      chk("t5_beat", beat0, k);
    end
    repeat (3) step();

    // Random valid and 50% ready stalls.
    acc0 = 0; cyc = 0;
    while (acc0 < 1000 && cyc < 30000) begin
      v_i     = ($urandom_range(3) != 0);
      data_i  = $urandom;
      ready_i = $urandom_range(1);
      step();
      cyc++;
    end
    chk("t4_word_count", acc0 >= 1000, 1);

    v_i = 1'b0; ready_i = 1'b1;
    repeat (10) step();
    chk("drain_q0", q[0].size(), 0);
    chk("drain_q1", q[1].size(), 0);
    chk("drain_q2", q[2].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
